// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: a scoreboard of in-flight destinations stalls RAW hazards,
// and a small FSM squashes the two shadow instructions behind every taken jump.
module hazard_controller #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       src0,
    input  logic [4:0]       src1,
    input  logic             src1_used,
    input  logic [4:0]       dst,
    input  logic             jmp_taken,
    output logic             stall,
    output logic             squash,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SQ1,
        SQ2
    } state_t;

    state_t     state;
    logic [4:0] sb [1:DEPTH];
    logic       hazard;

    // Register 0 never matches: a zero source or a zero entry can't form a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (sb[k] != 5'd0) begin
                if (src0 != 5'd0 && src0 == sb[k])
                    hazard = 1'b1;
                if (src1_used && src1 != 5'd0 && src1 == sb[k])
                    hazard = 1'b1;
            end
        end
    end

    assign squash = (state == SQ1) || (state == SQ2);
    assign stall  = hazard && !squash;

    // A stalled or squashed decode slot enters the pipe as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++)
                sb[k] <= 5'd0;
        end else begin
            for (int k = DEPTH; k >= 2; k--)
                sb[k] <= sb[k-1];
            sb[1] <= (stall || squash) ? 5'd0 : dst;
        end
    end

    // jmp_taken is ignored in SQ1 because that shadow is already being squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= jmp_taken ? SQ1 : IDLE;
                SQ1:     state <= SQ2;
                SQ2:     state <= jmp_taken ? SQ1 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: RAW stalls, x0, jumps, priority, saturation and reset.
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic        src1_used;
    logic [4:0]  dst;
    logic        jmp_taken;
    logic        stall;
    logic        squash;
    logic [15:0] stall_cnt;
    logic        stall_s;
    logic        squash_s;
    logic [1:0]  stall_cnt_s;

    int compared   = 0;
    int mismatched = 0;

    hazard_controller #(.DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src1_used(src1_used),
        .dst(dst), .jmp_taken(jmp_taken), .stall(stall), .squash(squash),
        .stall_cnt(stall_cnt)
    );

    hazard_controller #(.DEPTH(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .src0(src0), .src1(src1), .src1_used(src1_used),
        .dst(dst), .jmp_taken(jmp_taken), .stall(stall_s), .squash(squash_s),
        .stall_cnt(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one decode cycle just after the rising edge; outputs are settled on return.
    task automatic applyStimulus(input logic [4:0] s0, input logic [4:0] s1,
                                 input logic u1, input logic [4:0] d, input logic j);
        @(posedge clk);
        #1;
        src0 = s0; src1 = s1; src1_used = u1; dst = d; jmp_taken = j;
        #1;
    endtask

    initial begin
        rst = 1'b1; src0 = 0; src1 = 0; src1_used = 0; dst = 0; jmp_taken = 0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_squash", squash, 0);
        checkOutput("reset_cnt", stall_cnt, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_reset_stall", stall, 0);
        checkOutput("post_reset_squash", squash, 0);

        // RAW on r5: three stall cycles while the writer drains through sb[1..3]
        applyStimulus(0, 0, 0, 5, 0);
        checkOutput("raw_accept_stall", stall, 0);
        applyStimulus(5, 0, 0, 0, 0);
        checkOutput("raw_stall_1", stall, 1);
        applyStimulus(5, 0, 0, 0, 0);
        checkOutput("raw_stall_2", stall, 1);
        applyStimulus(5, 0, 0, 0, 0);
        checkOutput("raw_stall_3", stall, 1);
        applyStimulus(5, 0, 0, 0, 0);
        checkOutput("raw_release", stall, 0);
        checkOutput("raw_cnt", stall_cnt, 3);

        // x0: writes to and reads of register 0 never hazard
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("x0_stall_a", stall, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("x0_stall_b", stall, 0);

        // src1 only counts when src1_used is high
        applyStimulus(0, 0, 0, 7, 0);
        applyStimulus(0, 7, 0, 0, 0);
        checkOutput("src1_unused", stall, 0);
        applyStimulus(0, 7, 1, 0, 0);
        checkOutput("src1_stall_1", stall, 1);
        applyStimulus(0, 7, 1, 0, 0);
        checkOutput("src1_stall_2", stall, 1);
        applyStimulus(0, 7, 1, 0, 0);
        checkOutput("src1_release", stall, 0);
        checkOutput("cnt_after_src1", stall_cnt, 5);
        checkOutput("sat_cnt", stall_cnt_s, 3);

        // Jump: squash for two cycles; the squashed dst=9 must not reach the scoreboard
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("jmp_cycle_squash", squash, 0);
        applyStimulus(0, 0, 0, 9, 0);
        checkOutput("jmp_squash_1", squash, 1);
        applyStimulus(0, 0, 0, 9, 0);
        checkOutput("jmp_squash_2", squash, 1);
        applyStimulus(9, 0, 0, 0, 0);
        checkOutput("jmp_squash_end", squash, 0);
        checkOutput("jmp_bubble_no_hazard", stall, 0);

        // Priority: hazard on r12 during squash gives no stall and no count
        applyStimulus(0, 0, 0, 12, 1);
        applyStimulus(12, 0, 0, 0, 0);
        checkOutput("prio_stall_1", stall, 0);
        checkOutput("prio_squash_1", squash, 1);
        applyStimulus(12, 0, 0, 0, 0);
        checkOutput("prio_stall_2", stall, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("prio_cnt", stall_cnt, 5);

        // Back-to-back: jumps at N and N+2 keep squash high N+1..N+4
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_n1", squash, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("b2b_n2", squash, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_n3", squash, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_n4", squash, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("b2b_n5", squash, 0);

        // Jump during SQ1 is ignored
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("sq1_ignore_n1", squash, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sq1_ignore_n2", squash, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sq1_ignore_n3", squash, 0);

        // Reset asserted mid-SQ1 abandons the squash at once
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_pre_squash", squash, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_squash", squash, 0);
        checkOutput("rst_mid_cnt", stall_cnt, 0);
        checkOutput("rst_mid_sat_cnt", stall_cnt_s, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_held_squash", squash, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_release_squash", squash, 0);
        checkOutput("rst_release_stall", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have a parameter DEPTH, default 3: number of stages between decode-stage register read and register-file write-back.
REQ-002 SHALL have a parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src0  input  5  first source register identifier of the instruction in decode.
REQ-006 SHALL have port src1  input  5  second source register identifier of the instruction in decode.
REQ-007 SHALL have port src1_used  input  1  high when src1 is a real operand; low for immediate forms.
REQ-008 SHALL have port dst  input  5  destination register of the instruction in decode; 0 means no write.
REQ-009 SHALL have port jmp_taken  input  1  one-cycle pulse from execute: a jump/branch has resolved taken.
REQ-010 SHALL have port stall  output  1  freezes fetch and the decode input latch.
REQ-011 SHALL have port squash  output  1  converts the instruction in decode into a bubble.
REQ-012 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with stall high.

Function
REQ-013 SHALL keep a scoreboard of DEPTH 5-bit entries sb[1..DEPTH], holding destinations in flight; sb[1] is the youngest.
REQ-014 SHALL advance the scoreboard every cycle: sb[k+1] <= sb[k]; sb[DEPTH] is discarded.
REQ-015 SHALL load sb[1] <= dst when stall=0 and squash=0; otherwise sb[1] <= 0 (bubble).
REQ-016 SHALL flag a hazard combinationally when src0 != 0 and src0 equals any nonzero sb[k].
REQ-017 SHALL also flag a hazard when src1_used=1, src1 != 0 and src1 equals any nonzero sb[k].
REQ-018 SHALL never flag a hazard for register 0, regardless of scoreboard contents.
REQ-019 SHALL drive stall = hazard AND NOT squash, combinationally in the same cycle.
REQ-020 SHALL implement squash with a state machine: IDLE, SQ1, SQ2.
REQ-021 SHALL move IDLE -> SQ1 on jmp_taken=1.
REQ-022 SHALL move SQ1 -> SQ2 unconditionally.
REQ-023 SHALL move SQ2 -> IDLE, or SQ2 -> SQ1 if jmp_taken=1 in that cycle.
REQ-024 SHALL assert squash whenever state is SQ1 or SQ2, i.e. exactly 2 cycles per taken jump, starting the cycle after jmp_taken.
REQ-025 SHALL ignore jmp_taken while state is SQ1 (the jumping instruction's shadow is already squashed).
REQ-026 SHALL give squash priority over stall: a hazard during squash produces stall=0 and a bubble.
REQ-027 SHALL increment stall_cnt on each cycle with stall=1 and hold it at 2^CNT_W-1 (no wrap).
REQ-028 SHALL release a stall purely through scoreboard advance: a hazard on sb[k] clears after DEPTH-k+1 cycles with no new writer.

Reset
REQ-029 SHALL, on rst=1, asynchronously clear all sb entries to 0, state to IDLE, and stall_cnt to 0.
REQ-030 SHALL read stall=0 and squash=0 while rst=1 and in the first cycle after release, given inputs of 0.
REQ-031 SHALL abandon any squash or stall sequence in progress when rst is asserted mid-operation, without completing it.

Verification
REQ-032 SHALL be covered by a RAW test: dst=5 accepted, then src0=5 -> stall=1 for exactly 3 cycles, sb bubbles, stall_cnt=3.
REQ-033 SHALL be covered by an x0 test: dst=0 then src0=0, src1=0, src1_used=1 -> stall stays 0.
REQ-034 SHALL be covered by a jump test: jmp_taken pulse at cycle N -> squash=1 at N+1 and N+2, 0 at N+3; sb[1]=0 for both cycles.
REQ-035 SHALL be covered by a priority test: hazard pending while jmp_taken fires -> stall=0 during squash cycles, stall_cnt unchanged.
REQ-036 SHALL be covered by a back-to-back test: jmp_taken at N and N+2 -> squash high N+1..N+4 continuously.
REQ-037 SHALL be covered by saturation and reset tests: CNT_W=2, 5 stall cycles -> stall_cnt=3; rst mid-SQ1 -> squash=0 immediately, counter 0.
